btn_event_decoder: RTL and testbench

//  Consumer end of the debounced-button interface: takes one clean level from a

---
 rtl/btn_event_decoder.sv | 165 ++++++++++++++++
 tb/tb_btn_event_decoder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_event_decoder.sv
// Turns a debounced button level into 1-cycle press/release/click/long/double events.
// Optional double-click detection is enabled by defining BTN_DOUBLE_CLICK_EN.
module btn_event_decoder #(
  parameter int unsigned LONG_CYC = 50_000_000,
  parameter int unsigned DBL_CYC  = 15_000_000,
  parameter int unsigned CW       = 26
) (
  input  logic ckht,
  input  logic rst_n,
  input  logic db_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic click_pulse,
  output logic long_pulse,
  output logic dbl_pulse,
  output logic held
);

  if (LONG_CYC < 2 || DBL_CYC < 2 ||
      64'(LONG_CYC) > (64'd1 << CW) || 64'(DBL_CYC) > (64'd1 << CW)) begin : g_bad_cfg
    $error("btn_event_decoder: LONG_CYC/DBL_CYC must be >= 2 and fit in CW bits");
  end

  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    LONG
`ifdef BTN_DOUBLE_CLICK_EN
    , GAP,
    HOLD2
`endif
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lvl_d, lvl_q, lvl_prev_q;
  logic          rise, fall;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          click_q, click_d;
  logic          long_q, long_d;

  assign lvl_d = db_level;
  assign rise  = lvl_q & ~lvl_prev_q;
  assign fall  = ~lvl_q & lvl_prev_q;

`ifdef BTN_DOUBLE_CLICK_EN
  localparam logic [CW-1:0] DBL_LAST = CW'(DBL_CYC - 1);
  logic dbl_q, dbl_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    click_d = 1'b0;
    long_d  = 1'b0;
`ifdef BTN_DOUBLE_CLICK_EN
    dbl_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (rise) begin
          press_d = 1'b1;
          cnt_d   = '0;
          state_d = HOLD;
        end
      end
      // A release coinciding with the long threshold counts as a short press,
      // so the one-cycle fall event is never swallowed.
      HOLD: begin
        cnt_d = cnt_q + 1'b1;
        if (fall) begin
          rel_d = 1'b1;
`ifdef BTN_DOUBLE_CLICK_EN
          cnt_d   = '0;
          state_d = GAP;
`else
          click_d = 1'b1;
          state_d = IDLE;
`endif
        end else if (cnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          cnt_d   = cnt_q;
          state_d = LONG;
        end
      end
      LONG: begin
        if (fall) begin
          rel_d   = 1'b1;
          state_d = IDLE;
        end
      end
`ifdef BTN_DOUBLE_CLICK_EN
      GAP: begin
        cnt_d = cnt_q + 1'b1;
        if (rise) begin
          press_d = 1'b1;
          cnt_d   = '0;
          state_d = HOLD2;
        end else if (cnt_q == DBL_LAST) begin
          click_d = 1'b1;
          cnt_d   = cnt_q;
          state_d = IDLE;
        end
      end
      HOLD2: begin
        cnt_d = cnt_q + 1'b1;
        if (fall) begin
          rel_d   = 1'b1;
          dbl_d   = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          cnt_d   = cnt_q;
          state_d = LONG;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ckht or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      lvl_q      <= 1'b0;
      lvl_prev_q <= 1'b0;
      press_q    <= 1'b0;
      rel_q      <= 1'b0;
      click_q    <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lvl_q      <= lvl_d;
      lvl_prev_q <= lvl_q;
      press_q    <= press_d;
      rel_q      <= rel_d;
      click_q    <= click_d;
      long_q     <= long_d;
    end
  end

`ifdef BTN_DOUBLE_CLICK_EN
  always_ff @(posedge ckht or negedge rst_n) begin
    if (!rst_n) dbl_q <= 1'b0;
    else        dbl_q <= dbl_d;
  end
  assign dbl_pulse = dbl_q;
`else
  assign dbl_pulse = 1'b0;
`endif

  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign click_pulse   = click_q;
  assign long_pulse    = long_q;
  assign held          = lvl_q;

endmodule

// File: tb/tb_btn_event_decoder.sv
// Bench for btn_event_decoder: timestamp-based event model checked every cycle,
// plus directed literal checks; follows BTN_DOUBLE_CLICK_EN like the design.
module tb_btn_event_decoder;
  localparam int LONG_CYC = 8;
  localparam int DBL_CYC  = 5;
  localparam int CW       = 4;

  logic ckht = 1'b0;
  logic rst_n = 1'b0;
  logic db_level = 1'b0;
  logic press_pulse, release_pulse, click_pulse, long_pulse, dbl_pulse, held;

  int total = 0;
  int bad   = 0;

  always #5 ckht = ~ckht;

  btn_event_decoder #(
    .LONG_CYC(LONG_CYC),
    .DBL_CYC (DBL_CYC),
    .CW      (CW)
  ) dut (
    .ckht         (ckht),
    .rst_n        (rst_n),
    .db_level     (db_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .click_pulse  (click_pulse),
    .long_pulse   (long_pulse),
    .dbl_pulse    (dbl_pulse),
    .held         (held)
  );

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b want %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge ckht);
  endtask

  // Model: events derived from timestamps of sampled level changes.
  initial begin : model
    logic smp, rstv, h1, h2, rise, fall;
    logic e_press, e_rel, e_click, e_long, e_dbl, e_held;
    int   cyc, t_press, t_rel;
    bit   pressed, long_fired, pending, second;
    h1 = 1'b0; h2 = 1'b0; cyc = 0; t_press = 0; t_rel = 0;
    pressed = 0; long_fired = 0; pending = 0; second = 0;
    forever begin
      @(posedge ckht);
      smp  = db_level;
      rstv = rst_n;
      cyc++;
      #1;
      e_press = 1'b0; e_rel = 1'b0; e_click = 1'b0;
      e_long = 1'b0; e_dbl = 1'b0; e_held = 1'b0;
      if (!rstv) begin
        h1 = 1'b0; h2 = 1'b0;
        pressed = 0; long_fired = 0; pending = 0; second = 0;
      end else begin
        rise = h1 & ~h2;
        fall = ~h1 & h2;
        e_press = rise;
        e_rel   = fall;
        if (pressed && !long_fired && !fall && cyc == t_press + LONG_CYC) begin
          e_long = 1'b1;
          long_fired = 1;
        end
`ifdef BTN_DOUBLE_CLICK_EN
        if (pending && !rise && cyc == t_rel + DBL_CYC) begin
          e_click = 1'b1;
          pending = 0;
        end
        if (rise) begin
          second = pending;
          pending = 0;
          pressed = 1; long_fired = 0; t_press = cyc;
        end
        if (fall) begin
          pressed = 0;
          if (!long_fired) begin
            if (second) e_dbl = 1'b1;
            else begin
              pending = 1;
              t_rel = cyc;
            end
          end
          second = 0;
        end
`else
        if (rise) begin
          pressed = 1; long_fired = 0; t_press = cyc;
        end
        if (fall) begin
          pressed = 0;
          if (!long_fired) e_click = 1'b1;
        end
`endif
        e_held = smp;
        h2 = h1;
        h1 = smp;
      end
      chk("m_press",   press_pulse,   e_press);
      chk("m_release", release_pulse, e_rel);
      chk("m_click",   click_pulse,   e_click);
      chk("m_long",    long_pulse,    e_long);
      chk("m_dbl",     dbl_pulse,     e_dbl);
      chk("m_held",    held,          e_held);
    end
  end

  initial begin
    // 1: reset with level high, then long hold (12 clk) and release
    rst_n = 1'b0; db_level = 1'b1;
    wait_n(3);
    chk("rst_press", press_pulse, 1'b0);
    chk("rst_release", release_pulse, 1'b0);
    chk("rst_click", click_pulse, 1'b0);
    chk("rst_long", long_pulse, 1'b0);
    chk("rst_dbl", dbl_pulse, 1'b0);
    chk("rst_held", held, 1'b0);
    rst_n = 1'b1;
    wait_n(1);
    chk("t1_press_early", press_pulse, 1'b0);
    chk("t1_held", held, 1'b1);
    wait_n(1);
    chk("t1_press", press_pulse, 1'b1);
    wait_n(7);
    chk("t3_long_early", long_pulse, 1'b0);
    wait_n(1);
    chk("t3_long", long_pulse, 1'b1);
    wait_n(1);
    chk("t3_long_once", long_pulse, 1'b0);
    wait_n(1);
    db_level = 1'b0;
    wait_n(2);
    chk("t3_release", release_pulse, 1'b1);
    chk("t3_no_click", click_pulse, 1'b0);
    wait_n(8);

    // 2/5: short press
    db_level = 1'b1;
    wait_n(2);
    chk("t2_press", press_pulse, 1'b1);
    wait_n(1);
    db_level = 1'b0;
    wait_n(2);
    chk("t2_release", release_pulse, 1'b1);
    chk("t2_no_long", long_pulse, 1'b0);
`ifdef BTN_DOUBLE_CLICK_EN
    chk("t5_click_not_yet", click_pulse, 1'b0);
    wait_n(4);
    chk("t5_click_early", click_pulse, 1'b0);
    wait_n(1);
    chk("t5_click", click_pulse, 1'b1);
    chk("t5_no_dbl", dbl_pulse, 1'b0);
`else
    chk("t2_click", click_pulse, 1'b1);
`endif
    wait_n(8);

    // 4: press 2, low 2, press 2, low
    db_level = 1'b1;
    wait_n(2);
    chk("t4_press1", press_pulse, 1'b1);
    db_level = 1'b0;
    wait_n(2);
    chk("t4_release1", release_pulse, 1'b1);
`ifdef BTN_DOUBLE_CLICK_EN
    chk("t4_click1", click_pulse, 1'b0);
`else
    chk("t4_click1", click_pulse, 1'b1);
`endif
    db_level = 1'b1;
    wait_n(2);
    chk("t4_press2", press_pulse, 1'b1);
    db_level = 1'b0;
    wait_n(2);
    chk("t4_release2", release_pulse, 1'b1);
`ifdef BTN_DOUBLE_CLICK_EN
    chk("t4_dbl", dbl_pulse, 1'b1);
    chk("t4_click2", click_pulse, 1'b0);
`else
    chk("t4_dbl", dbl_pulse, 1'b0);
    chk("t4_click2", click_pulse, 1'b1);
`endif
    wait_n(10);

    // 6: second rise lands on the gap-timeout cycle
    db_level = 1'b1;
    wait_n(2);
    db_level = 1'b0;
    wait_n(2);
    chk("t6_release1", release_pulse, 1'b1);
    wait_n(3);
    db_level = 1'b1;
    wait_n(2);
    chk("t6_press2", press_pulse, 1'b1);
`ifdef BTN_DOUBLE_CLICK_EN
    chk("t6_no_click", click_pulse, 1'b0);
`endif
    db_level = 1'b0;
    wait_n(2);
    chk("t6_release2", release_pulse, 1'b1);
`ifdef BTN_DOUBLE_CLICK_EN
    chk("t6_dbl", dbl_pulse, 1'b1);
`else
    chk("t6_click", click_pulse, 1'b1);
`endif
    wait_n(10);

    // Level toggling every cycle
    for (int i = 0; i < 9; i++) begin
      db_level = ~db_level;
      wait_n(1);
    end
    db_level = 1'b0;
    wait_n(12);

    // Short press then a long second press
    db_level = 1'b1; wait_n(2);
    db_level = 1'b0; wait_n(1);
    db_level = 1'b1; wait_n(12);
    db_level = 1'b0; wait_n(12);

    // Reset mid-hold with the level still high
    db_level = 1'b1;
    wait_n(4);
    rst_n = 1'b0;
    wait_n(2);
    chk("rst_mid_press", press_pulse, 1'b0);
    chk("rst_mid_held", held, 1'b0);
    rst_n = 1'b1;
    wait_n(2);
    chk("rst_mid_repress", press_pulse, 1'b1);
    wait_n(3);
    db_level = 1'b0;
    wait_n(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
